sort_floats_seq: RTL
====================

# sort_floats_seq

Sequential N-element floating-point sorter that shares one `f_less_or_equal` comparator across all compare steps instead of instantiating a comparator network. It accepts a vector of N unsorted FLEN-bit floats through a valid/ready handshake and runs a bubble-sort schedule, one comparison per clock. It returns the ascending vector, plus a sticky error flag, through a second valid/ready handshake. It sits beside the combinational sorters as the area-optimised option for pipelines that tolerate multi-cycle latency.

## Interface
- `N`, default 3: number of elements; legal range 2..8.
- `FLEN`: global define from the shared config, not a parameter (normally 64).
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous assert, active-low.
- `up_valid` input, 1 bit: `up_data` holds a job.
- `up_ready` output, 1 bit: block can accept a job; high only in IDLE.
- `up_data` input, [0:N-1][FLEN-1:0]: unsorted elements.
- `down_valid` output, 1 bit: result is available.
- `down_ready` input, 1 bit: consumer accepts the result.
- `down_data` output, [0:N-1][FLEN-1:0]: sorted elements; `down_data[0]` is the smallest.
- `down_err` output, 1 bit: at least one comparison of this job reported `err`.

## Operation
- Exactly one `f_less_or_equal` instance. Its inputs are `a = buf[j]` and `b = buf[j+1]`, where `buf` is the internal N-entry register array.
- State machine has three states: IDLE, SORT, DONE.
- **IDLE**
  - `up_ready=1`.
  - On `up_valid & up_ready`: `buf <= up_data`, `err_acc <= 0`, `pass <= 0`, `j <= 0`, go to SORT.
- **SORT** (one comparison per cycle)
  - If `!res & !err`: swap `buf[j]` and `buf[j+1]`.
  - If `res`: no swap, so equal values keep their order and the sort is stable.
  - If `err`: no swap, and `err_acc <= 1`.
- **SORT index advance**
  - If `j == N-2-pass`: `j <= 0` and `pass <= pass+1`.
  - Otherwise `j <= j+1`.
- **SORT exit**: after the last compare (`pass == N-2` and `j == 0`), go to DONE.
- **DONE**
  - `down_valid=1`, `down_data = buf`, `down_err = err_acc`.
  - These outputs are held stable until `down_valid & down_ready`, then go to IDLE.
- **Compare count**: total compares per job is C = N(N-1)/2, with no data-dependent early exit. N=3 gives C=3; N=8 gives C=28.
- **Counter widths**: `pass` and `j` are each $clog2(N) bits. They must never index past `buf[N-1]`.
- **Output source**: `down_data` is driven directly from `buf`. Its value is only meaningful while `down_valid=1`.
- **Reset values**
  - state = IDLE, so `up_ready=1` once reset is released.
  - `down_valid=0`, `down_err=0`.
  - `buf` all zeros, so `down_data` = 0.
  - `pass=0`, `j=0`.
- **Reset mid-job**: the job is discarded immediately (asynchronously). No partial result ever appears.
- **Input handshake**
  - `up_valid` asserted outside IDLE is ignored and not captured.
  - The upstream must hold `up_data` until `up_ready` is seen.
- **NaN handling**: a NaN anywhere yields a result that is not guaranteed sorted, with `down_err=1`. The job still completes in exactly C cycles.

## Timing
- **Input accept**: handshake in cycle t. Compares happen in cycles t+1 .. t+C. `down_valid` rises in cycle t+C+1. For N=3 this is cycle t+4.
- **Output release**: `down_ready` high in the first DONE cycle gives `down_valid` for exactly 1 cycle and `up_ready=1` the next cycle.
- **Throughput**: minimum job-to-job interval is C+2 cycles.
- **Backpressure**: `down_ready` held low keeps DONE indefinitely. `down_data` and `down_err` must not change during the stall.
- **Combinational paths**: `up_ready` and `down_valid` are decoded from the state register only, with no combinational path from `up_valid` or `down_ready`.
- **Critical path**: one comparator, a swap mux, and the `buf` registers.

## Test plan
- **N=3, ascending input**: `{1.0, 2.0, 3.0}` = `{3FF0…0, 4000…0, 4008…0}` -> output `{1.0, 2.0, 3.0}`, `down_err=0`, `down_valid` exactly 4 cycles after accept.
- **N=3, reversed input**: `{3.0, 2.0, 1.0}` -> `{1.0, 2.0, 3.0}`. Also check `{2.0, -1.0, -1.0}` (-1.0 = BFF0…0) -> `{-1.0, -1.0, 2.0}`.
- **N=3, NaN input**: `{1.0, 7FF8000000000000, 2.0}` -> `down_err=1`, `down_valid` still at accept+4. The next clean job then reports `down_err=0`.
- **Backpressure**: hold `down_ready=0` for 10 cycles in DONE -> `down_data` constant, `up_ready=0` throughout, new `up_valid` not captured. Release -> single handshake, then `up_ready=1` on the next cycle.
- **Reset mid-sort**: drop `rst_n` in the 2nd compare cycle -> outputs immediately return to reset values (`down_valid=0`, `up_ready=1`). A new job after release sorts correctly.
- **N=8 random regression**: 1000 random FP64 vectors, including ±0 and denormals, checked against a reference sort -> every result matches and latency is 29 cycles.

Source files
------------

// File: rtl/sort_floats_seq_if.sv
// ----------------------------------------------------------------------------
// sort_floats_seq_if
// Handshake bundle for the sequential float sorter.
//   up_valid / up_ready / up_data         : job in, unsorted vector
//   down_valid / down_ready / down_data   : job out, ascending vector
//   down_err                              : a comparison of this job hit a NaN
// master = producer/consumer side, slave = sorter side.
// ----------------------------------------------------------------------------
`ifndef FLEN
`define FLEN 64
`endif

interface sort_floats_seq_if #(
    parameter int N = 3
) ();
    logic                          up_valid;
    logic                          up_ready;
    logic [0:N-1][`FLEN-1:0]       up_data;
    logic                          down_valid;
    logic                          down_ready;
    logic [0:N-1][`FLEN-1:0]       down_data;
    logic                          down_err;

    modport master (
        output up_valid, up_data, down_ready,
        input  up_ready, down_valid, down_data, down_err
    );

    modport slave (
        input  up_valid, up_data, down_ready,
        output up_ready, down_valid, down_data, down_err
    );
endinterface

// File: rtl/sort_floats_seq.sv
// ----------------------------------------------------------------------------
// sort_floats_seq
// Area-optimised float sorter: one shared comparator walks a bubble-sort
// schedule, one compare per clock, N(N-1)/2 compares per job, no early exit.
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sort_floats_seq_if.slave (job in, sorted vector + error out)
// Also contains f_less_or_equal, the IEEE-754 a <= b comparator
// (err = either operand NaN, -0 == +0).
// ----------------------------------------------------------------------------
`ifndef FLEN
`define FLEN 64
`endif

module f_less_or_equal (
    input  logic [`FLEN-1:0] a,
    input  logic [`FLEN-1:0] b,
    output logic             res,
    output logic             err
);
    localparam int EXP_W = (`FLEN == 16) ? 5 : (`FLEN == 32) ? 8 : 11;
    localparam int MAN_W = `FLEN - 1 - EXP_W;

    logic a_nan, b_nan, a_zero, b_zero;

    assign a_nan  = (&a[`FLEN-2 -: EXP_W]) && (|a[MAN_W-1:0]);
    assign b_nan  = (&b[`FLEN-2 -: EXP_W]) && (|b[MAN_W-1:0]);
    assign a_zero = ~|a[`FLEN-2:0];
    assign b_zero = ~|b[`FLEN-2:0];

    // Sign-magnitude ordering: for negatives a larger magnitude is smaller.
    always_comb begin
        err = a_nan | b_nan;
        res = 1'b0;
        if (!err) begin
            if (a_zero && b_zero)
                res = 1'b1;
            else if (a[`FLEN-1] != b[`FLEN-1])
                res = a[`FLEN-1];
            else if (!a[`FLEN-1])
                res = (a[`FLEN-2:0] <= b[`FLEN-2:0]);
            else
                res = (a[`FLEN-2:0] >= b[`FLEN-2:0]);
        end
    end
endmodule

module sort_floats_seq #(
    parameter int N = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    sort_floats_seq_if.slave   bus
);
    localparam int              CW        = $clog2(N);
    localparam logic [CW-1:0]   LAST_PASS = CW'(N - 2);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t                     state_q, state_d;
    logic [0:N-1][`FLEN-1:0]    buf_q, buf_d;
    logic [CW-1:0]              pass_q, pass_d;
    logic [CW-1:0]              j_q, j_d;
    logic                       err_q, err_d;

    logic [CW-1:0]              j_nxt;
    logic [CW-1:0]              j_last;
    logic                       cmp_res, cmp_err;

    // j never exceeds N-2, so j+1 always addresses a valid entry.
    assign j_nxt  = j_q + CW'(1);
    // Inner loop shrinks by one per pass; pass never exceeds N-2.
    assign j_last = LAST_PASS - pass_q;

    f_less_or_equal u_cmp (
        .a   (buf_q[j_q]),
        .b   (buf_q[j_nxt]),
        .res (cmp_res),
        .err (cmp_err)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        pass_d  = pass_q;
        j_d     = j_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.up_valid) begin
                    buf_d   = bus.up_data;
                    err_d   = 1'b0;
                    pass_d  = '0;
                    j_d     = '0;
                    state_d = SORT;
                end
            end
            SORT: begin
                // Swap only on a clean "a > b": equal keys keep order (stable).
                if (cmp_err) begin
                    err_d = 1'b1;
                end else if (!cmp_res) begin
                    buf_d[j_q]   = buf_q[j_nxt];
                    buf_d[j_nxt] = buf_q[j_q];
                end
                if (j_q == j_last) begin
                    j_d = '0;
                    if (pass_q == LAST_PASS) begin
                        pass_d  = '0;
                        state_d = DONE;
                    end else begin
                        pass_d = pass_q + CW'(1);
                    end
                end else begin
                    j_d = j_nxt;
                end
            end
            DONE: begin
                if (bus.down_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            pass_q  <= '0;
            j_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pass_q  <= pass_d;
            j_q     <= j_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs decode the state register only.
    assign bus.up_ready   = (state_q == IDLE);
    assign bus.down_valid = (state_q == DONE);
    assign bus.down_data  = buf_q;
    assign bus.down_err   = err_q;
endmodule
